// File: rtl/link_arbiter.sv
// rtl/link_arbiter.sv - round-robin link arbiter with per-tenure beat limit
module link_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic                      link_ready,
  output logic [N_REQ-1:0]          gnt,
  output logic                      link_valid,
  output logic [DATA_W-1:0]         link_data,
  output logic                      link_last,
  output logic                      cut,
  output logic [15:0]               xfer_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam logic [3:0]       LAST_BEAT = 4'(MAX_BEATS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [3:0]        beat_q, beat_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              cut_q, cut_d;
  logic [15:0]       xfer_cnt_q, xfer_cnt_d;

  logic              owner_req;
  logic              owner_last;
  logic [DATA_W-1:0] owner_data;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              in_xfer;
  logic              accept;
  logic [IDX_W-1:0]  ptr_after_owner;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_req  = req[i];
        owner_last = req_last[i];
        owner_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Scan from the highest offset down so the candidate closest to ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  assign in_xfer         = (state_q == ST_XFER);
  assign link_valid      = in_xfer & owner_req;
  assign link_data       = in_xfer ? owner_data : '0;
  assign link_last       = in_xfer & (owner_last | (beat_q == LAST_BEAT));
  assign accept          = link_valid & link_ready;
  assign ptr_after_owner = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    beat_d     = beat_q;
    gnt_d      = gnt_q;
    cut_d      = 1'b0;
    xfer_cnt_d = xfer_cnt_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          state_d = ST_XFER;
          owner_d = pick_idx;
          gnt_d   = N_REQ'(1) << pick_idx;
        end
      end
      ST_XFER: begin
        if (!owner_req || (accept && link_last)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_after_owner;
          beat_d  = '0;
          // Abort (owner dropped req) neither counts nor cuts.
          if (owner_req) begin
            cut_d = ~owner_last;
            if (xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
          end
        end else if (accept) begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      beat_q     <= '0;
      gnt_q      <= '0;
      cut_q      <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      beat_q     <= beat_d;
      gnt_q      <= gnt_d;
      cut_q      <= cut_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign cut      = cut_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_link_arbiter.sv
// tb/tb_link_arbiter.sv - scoreboard bench for link_arbiter
module tb_link_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic        link_ready;
  logic [3:0]  gnt;
  logic        link_valid;
  logic [7:0]  link_data;
  logic        link_last;
  logic        cut;
  logic [15:0] xfer_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cut = 0;
  logic [12:0] exp_q[$];

  link_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
    .link_ready(link_ready), .gnt(gnt), .link_valid(link_valid), .link_data(link_data),
    .link_last(link_last), .cut(cut), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] d, input logic l);
    exp_q.push_back({g, d, l});
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  // Monitor: invariants every cycle, scoreboard on every accepted beat.
  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst) begin
      n_cmp++;
      if ($countones(gnt) > 1 || (link_valid && gnt == 4'b0)) begin
        n_bad++;
        $display("FAIL gnt_onehot: gnt=%b link_valid=%b", gnt, link_valid);
      end
      if (cut) n_cut++;
      if (link_valid && link_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: gnt=%b data=%h last=%b expected none", gnt, link_data, link_last);
        end else begin
          e = exp_q.pop_front();
          if ({gnt, link_data, link_last} !== e) begin
            n_bad++;
            $display("FAIL beat: got gnt=%b data=%h last=%b expected gnt=%b data=%h last=%b",
                     gnt, link_data, link_last, e[12:9], e[8:1], e[0]);
          end
        end
      end
    end
  end

  logic [3:0] rr_seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                             4'b0000, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    rst = 1'b1; req = '0; req_last = '0; link_ready = 1'b1;
    req_data = 32'h44332211;
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(link_valid), 0);
    chk("rst_last", 32'(link_last), 0);
    chk("rst_cut", 32'(cut), 0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Round robin, one beat per tenure
    @(posedge clk); #1;
    req = 4'b1111; req_last = 4'b1111;
    push(4'b0001, 8'h11, 1); push(4'b0010, 8'h22, 1); push(4'b0100, 8'h33, 1);
    push(4'b1000, 8'h44, 1); push(4'b0001, 8'h11, 1);
    @(negedge clk);
    chk("rr_idle0", 32'(gnt), 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(rr_seq[k]));
    end
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("rr_xfer_cnt", 32'(xfer_cnt), 5);
    chk("rr_no_cut", n_cut, 0);

    // Single request on requester 2
    @(posedge clk); #1;
    req = 4'b0100; req_last = 4'b0100; set_data(2, 8'hA5);
    push(4'b0100, 8'hA5, 1);
    @(negedge clk);
    chk("single_latency", 32'(gnt), 0);
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h4);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("single_gnt_off", 32'(gnt), 0);
    chk("single_xfer_cnt", 32'(xfer_cnt), 6);

    // ptr should now be 3
    @(posedge clk); #1;
    req = 4'b1111; req_last = 4'b1111;
    push(4'b1000, 8'h44, 1);
    @(posedge clk);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("ptr3_xfer_cnt", 32'(xfer_cnt), 7);

    // Beat limit on requester 1
    @(posedge clk); #1;
    req = 4'b0010; req_last = '0; set_data(1, 8'hB0);
    push(4'b0010, 8'hB0, 0); push(4'b0010, 8'hB1, 0);
    push(4'b0010, 8'hB2, 0); push(4'b0010, 8'hB3, 1);
    @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      set_data(1, 8'hB1 + 8'(b));
    end
    req = '0;
    repeat (3) @(negedge clk);
    chk("limit_cut_once", n_cut, 1);
    chk("limit_xfer_cnt", 32'(xfer_cnt), 8);

    // Reset mid-tenure (ptr is 2 here)
    @(posedge clk); #1;
    req = 4'b0100; req_last = '0; link_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_gnt_before", 32'(gnt), 32'h4);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_gnt", 32'(gnt), 0);
    chk("rst_mid_valid", 32'(link_valid), 0);
    chk("rst_mid_last", 32'(link_last), 0);
    chk("rst_mid_xfer_cnt", 32'(xfer_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0; req = 4'b1111; req_last = 4'b1111; link_ready = 1'b1;
    push(4'b0001, 8'h11, 1);
    @(posedge clk);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("rst_after_xfer_cnt", 32'(xfer_cnt), 1);

    // Stall mid-tenure on requester 2
    @(posedge clk); #1;
    req = 4'b0100; req_last = '0; set_data(2, 8'hC0);
    push(4'b0100, 8'hC0, 0); push(4'b0100, 8'hC4, 0);
    push(4'b0100, 8'hC5, 0); push(4'b0100, 8'hC6, 1);
    @(posedge clk);
    @(posedge clk); #1;
    link_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_data(2, 8'hC1 + 8'(s));
      @(negedge clk);
      chk($sformatf("stall_gnt%0d", s), 32'(gnt), 32'h4);
      chk($sformatf("stall_data%0d", s), 32'(link_data), 32'(8'hC1 + 8'(s)));
      chk($sformatf("stall_valid%0d", s), 32'(link_valid), 1);
      @(posedge clk); #1;
    end
    link_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      set_data(2, 8'hC4 + 8'(b));
      @(posedge clk); #1;
    end
    req = '0;
    repeat (2) @(negedge clk);
    chk("stall_cut", n_cut, 2);
    chk("stall_xfer_cnt", 32'(xfer_cnt), 2);

    // Abort: requester 3 drops req after one beat
    @(posedge clk); #1;
    req = 4'b1000; req_last = '0; set_data(3, 8'hD0);
    push(4'b1000, 8'hD0, 0);
    @(posedge clk);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("abort_gnt_held", 32'(gnt), 32'h8);
    @(negedge clk);
    chk("abort_gnt_off", 32'(gnt), 0);
    chk("abort_xfer_cnt", 32'(xfer_cnt), 2);
    chk("abort_no_cut", n_cut, 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/link_arbiter.md
LINK_ARBITER -- requirements
Module: link_arbiter

Interface
REQ-001 SHALL provide parameter N_REQ, default 4, number of requesters sharing the link (2..8).
REQ-002 SHALL provide parameter DATA_W, default 8, link data width.
REQ-003 SHALL provide parameter MAX_BEATS, default 4, beat limit per grant tenure (1..15).
REQ-004 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port req  input  N_REQ  per-requester request/valid.
REQ-007 SHALL provide port req_last  input  N_REQ  per-requester last-beat marker.
REQ-008 SHALL provide port req_data  input  N_REQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL provide port link_ready  input  1  downstream accepts beat.
REQ-010 SHALL provide port gnt  output  N_REQ  one-hot grant, registered.
REQ-011 SHALL provide port link_valid  output  1  beat presented on shared link.
REQ-012 SHALL provide port link_data  output  DATA_W  data of granted requester.
REQ-013 SHALL provide port link_last  output  1  last marker of granted requester, or forced-last at beat limit.
REQ-014 SHALL provide port cut  output  1  one-cycle pulse when a tenure ends by beat limit.
REQ-015 SHALL provide port xfer_cnt  output  16  count of completed tenures, saturating at 16'hFFFF.

Function
REQ-016 SHALL implement states IDLE and XFER; registered owner index, rotating pointer ptr, beat counter.
REQ-017 IDLE: if req!=0 at an edge, SHALL select the first set req bit scanning ptr, ptr+1, ... wrapping mod N_REQ; gnt one-hot for it and state XFER from the next cycle (1-cycle latency req->gnt).
REQ-018 IDLE: gnt SHALL be 0, link_valid 0; no req keeps IDLE.
REQ-019 XFER: link_valid SHALL equal req[owner]; link_data and link_last SHALL combinationally mux owner's inputs.
REQ-020 Beat accepted when link_valid && link_ready; beat counter SHALL increment only on accepted beats.
REQ-021 link_last SHALL also be 1 when beat counter equals MAX_BEATS-1, regardless of req_last[owner].
REQ-022 Tenure SHALL end on an accepted beat with link_last=1; next state IDLE, gnt 0 next cycle.
REQ-023 If the ending beat has req_last[owner]=0 (beat limit), cut SHALL pulse 1 in the cycle after acceptance.
REQ-024 If req[owner] is 0 in XFER, tenure SHALL abort: IDLE next cycle, no beat counted, xfer_cnt unchanged.
REQ-025 On every tenure end (complete, cut or abort), ptr SHALL become (owner+1) mod N_REQ and beat counter 0.
REQ-026 xfer_cnt SHALL increment on complete or cut tenures only; hold at 16'hFFFF.
REQ-027 There SHALL be exactly one IDLE cycle between tenures; gnt SHALL never have more than one bit set.
REQ-028 Requests from non-owners during XFER SHALL be ignored until next IDLE arbitration.
REQ-029 link_ready low SHALL stall the beat; data passes through unregistered, no buffering.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, gnt 0, owner 0, ptr 0, beat counter 0, cut 0, xfer_cnt 0; hence link_valid 0 and link_last 0.
REQ-031 Reset asserted mid-tenure SHALL drop gnt without completing the tenure; after release arbitration restarts from ptr 0.

Verification
REQ-032 Single request: req=4'b0100, data 8'hA5, req_last=1, link_ready=1 -> gnt=4'b0100 one cycle later, link_data=A5, link_last=1, then gnt=0, xfer_cnt=1, ptr=3.
REQ-033 Round robin: req=4'b1111 held, each tenure one beat -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-034 Beat limit: MAX_BEATS=4, requester 1 never asserts last -> 4 accepted beats, link_last=1 on 4th, cut pulses once, xfer_cnt+1.
REQ-035 Stall: link_ready=0 for 3 cycles mid-tenure -> beat counter frozen, gnt held, link_data tracks owner input.
REQ-036 Abort and reset: owner drops req after 1 beat -> IDLE next cycle, xfer_cnt unchanged; rst asserted during XFER -> gnt=0 same cycle, ptr=0 after release.
REQ-037 Bench SHALL assert gnt one-hot-or-zero and link_valid -> (gnt!=0) every cycle.
